// File: rtl/func_rr_unit_if.sv
// Handshake bundle for func_rr_unit: round-robin input channels with a single result port.
// The unit connects through the slave modport; producers and the consumer use the master modport.
interface func_rr_unit_if #(
   parameter int WIDTH = 32,
   parameter int NCH   = 2
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [1:0]         mode;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]     in_sync;
   logic [NCH-1:0]     in_notify;
   logic [WIDTH-1:0]   out_data;
   logic [CW-1:0]      out_ch;
   logic               out_sync;
   logic               out_notify;

   modport slave (
      input  mode, in_data, in_sync, out_sync,
      output in_notify, out_data, out_ch, out_notify
   );

   modport master (
      output mode, in_data, in_sync, out_sync,
      input  in_notify, out_data, out_ch, out_notify
   );
endinterface

// File: rtl/func_rr_unit.sv
// Round-robin polling function unit: takes one word from the polled channel, applies
// ABS / RELU2 / per-channel accumulate / drain, then presents the result until it is accepted.
module func_rr_unit #(
   parameter int WIDTH = 32,
   parameter int NCH   = 2
) (
   input  logic          clk,
   input  logic          rst,
   func_rr_unit_if.slave bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {SEC_READ, SEC_WRITE} section_t;

   section_t         r_sect, w_sectNext;
   logic [CW-1:0]    r_ptr, w_ptrNext;
   logic [CW-1:0]    r_outCh, w_outChNext;
   logic [WIDTH-1:0] r_outData, w_outDataNext;
   logic [NCH-1:0]   r_inNotify, w_inNotifyNext;
   logic [WIDTH-1:0] r_acc [NCH];

   logic [WIDTH-1:0] w_x, w_accCur, w_accNext, w_result;
   logic             w_syncSel, w_accWrite;

   function automatic logic [CW-1:0] nextCh(input logic [CW-1:0] c);
      if (NCH == 1 || c == CW'(NCH - 1)) return '0;
      return c + CW'(1);
   endfunction

   always_comb begin
      w_x       = '0;
      w_accCur  = '0;
      w_syncSel = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (r_ptr == CW'(k)) begin
            w_x       = bus.in_data[k*WIDTH +: WIDTH];
            w_accCur  = r_acc[k];
            w_syncSel = bus.in_sync[k];
         end
      end
   end

   // Result datapath; the sign bit of x picks the ABS/RELU2 branch directly.
   always_comb begin
      w_result  = '0;
      w_accNext = w_accCur;
      unique case (bus.mode)
         2'd0: w_result = w_x[WIDTH-1] ? (WIDTH'(0) - w_x) : w_x;
         2'd1: w_result = w_x[WIDTH-1] ? '0 : {w_x[WIDTH-2:0], 1'b0};
         2'd2: begin
            w_accNext = w_accCur + w_x;
            w_result  = w_accNext;
         end
         default: begin
            w_accNext = '0;
            w_result  = w_accCur;
         end
      endcase
   end

   always_comb begin
      w_sectNext    = r_sect;
      w_ptrNext     = r_ptr;
      w_outChNext   = r_outCh;
      w_outDataNext = r_outData;
      w_accWrite    = 1'b0;
      unique case (r_sect)
         SEC_READ: begin
            if (w_syncSel) begin
               w_sectNext    = SEC_WRITE;
               w_outDataNext = w_result;
               w_outChNext   = r_ptr;
               w_accWrite    = bus.mode[1];
            end else begin
               w_ptrNext = nextCh(r_ptr);
            end
         end
         SEC_WRITE: begin
            if (bus.out_sync) begin
               w_sectNext = SEC_READ;
               w_ptrNext  = nextCh(r_outCh);
            end
         end
         default: w_sectNext = SEC_READ;
      endcase
   end

   always_comb begin
      w_inNotifyNext = '0;
      for (int k = 0; k < NCH; k++) begin
         if (w_sectNext == SEC_READ && w_ptrNext == CW'(k)) w_inNotifyNext[k] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sect     <= SEC_READ;
         r_ptr      <= '0;
         r_outCh    <= '0;
         r_outData  <= '0;
         r_inNotify <= NCH'(1);
      end else begin
         r_sect     <= w_sectNext;
         r_ptr      <= w_ptrNext;
         r_outCh    <= w_outChNext;
         r_outData  <= w_outDataNext;
         r_inNotify <= w_inNotifyNext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
      end else if (w_accWrite) begin
         for (int k = 0; k < NCH; k++) begin
            if (r_ptr == CW'(k)) r_acc[k] <= w_accNext;
         end
      end
   end

   assign bus.in_notify  = r_inNotify;
   assign bus.out_notify = (r_sect == SEC_WRITE);
   assign bus.out_data   = r_outData;
   assign bus.out_ch     = r_outCh;
endmodule

// File: tb/tb_func_rr_unit.sv
// Bench for func_rr_unit (WIDTH=8, NCH=3): directed scenarios with literal expectations,
// then randomized traffic, all tracked by a cycle-level behavioural model.
module tb_func_rr_unit;
   localparam int W = 8;
   localparam int N = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   func_rr_unit_if #(.WIDTH(W), .NCH(N)) bus ();

   func_rr_unit #(.WIDTH(W), .NCH(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   bit checkOn = 1'b0;

   int mPtr;
   bit mBusy;
   int mData;
   int mCh;
   int mAcc [N];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: a busy flag plus pending result; polling and arithmetic done on plain integers.
   always @(posedge clk or posedge rst) begin : model
      logic signed [W-1:0] w;
      int x;
      if (rst) begin
         mPtr = 0; mBusy = 0; mData = 0; mCh = 0;
         for (int k = 0; k < N; k++) mAcc[k] = 0;
      end else if (!mBusy) begin
         if (bus.in_sync[mPtr] === 1'b1) begin
            w = bus.in_data[mPtr*W +: W];
            x = w;
            case (bus.mode)
               2'd0: mData = (x < 0) ? -x : x;
               2'd1: mData = (x < 0) ? 0 : 2 * x;
               2'd2: begin
                  mAcc[mPtr] = ((mAcc[mPtr] + x) % 256 + 256) % 256;
                  mData = mAcc[mPtr];
               end
               default: begin
                  mData = mAcc[mPtr];
                  mAcc[mPtr] = 0;
               end
            endcase
            mCh   = mPtr;
            mBusy = 1;
         end else begin
            mPtr = (mPtr + 1) % N;
         end
      end else if (bus.out_sync === 1'b1) begin
         mBusy = 0;
         mPtr  = (mCh + 1) % N;
      end
   end

   always @(negedge clk) begin
      if (checkOn) begin
         checkOutput("model in_notify", 32'(bus.in_notify), mBusy ? 32'd0 : (32'd1 << mPtr));
         checkOutput("model out_notify", 32'(bus.out_notify), 32'(mBusy));
         if (mBusy) begin
            checkOutput("model out_data", 32'(bus.out_data), 32'(mData));
            checkOutput("model out_ch", 32'(bus.out_ch), 32'(mCh));
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] s, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [1:0] m, input logic os);
      bus.in_sync  = s;
      bus.in_data  = {d2, d1, d0};
      bus.mode     = m;
      bus.out_sync = os;
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      #1;
      checkOutput("reset out_notify", 32'(bus.out_notify), 32'd0);
      checkOutput("reset in_notify", 32'(bus.in_notify), 32'd1);
      checkOutput("reset out_data", 32'(bus.out_data), 32'd0);
      checkOutput("reset out_ch", 32'(bus.out_ch), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idleTo(input int ch);
      for (int i = 0; i < N + 1 && bus.in_notify !== 3'(1 << ch); i++) applyStimulus(3'b000, 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
      checkOutput("reach channel", 32'(bus.in_notify), 32'd1 << ch);
   endtask

   task automatic release1();
      applyStimulus(3'b000, 8'h0, 8'h0, 8'h0, 2'd0, 1'b1);
   endtask

   initial begin
      bus.in_sync = '0; bus.in_data = '0; bus.mode = '0; bus.out_sync = 1'b0;
      #1;
      applyReset();
      checkOn = 1'b1;
      checkOutput("first notify", 32'(bus.in_notify), 32'h1);

      applyStimulus(3'b000, 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
      checkOutput("idle 1", 32'(bus.in_notify), 32'h2);
      applyStimulus(3'b000, 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
      checkOutput("idle 2", 32'(bus.in_notify), 32'h4);
      applyStimulus(3'b000, 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
      checkOutput("idle wrap", 32'(bus.in_notify), 32'h1);

      applyStimulus(3'b001, 8'hFB, 8'h0, 8'h0, 2'd0, 1'b0);
      checkOutput("abs -5 notify", 32'(bus.out_notify), 32'd1);
      checkOutput("abs -5 data", 32'(bus.out_data), 32'd5);
      checkOutput("abs -5 ch", 32'(bus.out_ch), 32'd0);
      checkOutput("write in_notify", 32'(bus.in_notify), 32'd0);
      release1();
      checkOutput("after write notify", 32'(bus.in_notify), 32'h2);

      idleTo(0);
      applyStimulus(3'b001, 8'h80, 8'h0, 8'h0, 2'd0, 1'b0);
      checkOutput("abs -128", 32'(bus.out_data), 32'd128);
      release1();
      idleTo(1);
      applyStimulus(3'b010, 8'h0, 8'd100, 8'h0, 2'd1, 1'b0);
      checkOutput("relu2 100", 32'(bus.out_data), 32'd200);
      checkOutput("relu2 ch", 32'(bus.out_ch), 32'd1);
      release1();
      idleTo(1);
      applyStimulus(3'b010, 8'h0, 8'hFD, 8'h0, 2'd1, 1'b0);
      checkOutput("relu2 -3", 32'(bus.out_data), 32'd0);
      release1();

      idleTo(2);
      applyStimulus(3'b100, 8'h0, 8'h0, 8'd200, 2'd2, 1'b0);
      checkOutput("acc 200", 32'(bus.out_data), 32'd200);
      release1();
      idleTo(2);
      applyStimulus(3'b100, 8'h0, 8'h0, 8'd100, 2'd2, 1'b0);
      checkOutput("acc wrap", 32'(bus.out_data), 32'd44);
      release1();
      idleTo(2);
      applyStimulus(3'b100, 8'h0, 8'h0, 8'd77, 2'd3, 1'b0);
      checkOutput("drain", 32'(bus.out_data), 32'd44);
      release1();
      idleTo(2);
      applyStimulus(3'b100, 8'h0, 8'h0, 8'd1, 2'd2, 1'b0);
      checkOutput("acc after drain", 32'(bus.out_data), 32'd1);
      release1();

      idleTo(2);
      applyStimulus(3'b100, 8'h0, 8'h0, 8'd7, 2'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(3'b111, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b0);
         checkOutput("hold data", 32'(bus.out_data), 32'd7);
         checkOutput("hold ch", 32'(bus.out_ch), 32'd2);
         checkOutput("hold in_notify", 32'(bus.in_notify), 32'd0);
      end
      release1();
      checkOutput("wrap after write", 32'(bus.in_notify), 32'h1);

      idleTo(1);
      applyStimulus(3'b010, 8'h0, 8'd9, 8'h0, 2'd2, 1'b0);
      checkOutput("acc 9", 32'(bus.out_data), 32'd9);
      applyReset();
      for (int ch = 0; ch < N; ch++) begin
         idleTo(ch);
         applyStimulus(3'(1 << ch), 8'h0, 8'h0, 8'h0, 2'd3, 1'b0);
         checkOutput("acc cleared", 32'(bus.out_data), 32'd0);
         release1();
      end

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) applyReset();
         applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                       2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
